uart_tx_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one `uart_transmitter` byte port among `NUM_SRC` byte-stream requesters. It sits directly upstream of the transmitter. It drives the transmitter's `data_in`/`data_valid` and honours its `fifo_full`. It grants one source at a time and holds the grant until that source's packet ends, so bytes from different sources never interleave on the serial line.

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter byte port among NUM_SRC sources.
// Optional per-grant byte limit (MAX_BURST) enabled by defining UART_ARB_BURST_LIMIT_EN.
module uart_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_SRC-1:0]   i_src_req,
    input  logic [8*NUM_SRC-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]   i_src_last,
    output logic [NUM_SRC-1:0]   o_src_ack,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_fifo_full,
    output logic                 o_grant_valid,
    output logic [2:0]           o_grant_id
);
    localparam int SEL_W = $clog2(NUM_SRC);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           r_state;
    logic             r_grant_valid;
    logic [2:0]       r_grant_id;
    logic [2:0]       r_rr_ptr;
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] w_cand;
    logic             w_accept;
    logic             w_found;
    logic             w_release;
    logic [2:0]       w_winner;

    assign w_sel    = r_grant_id[SEL_W-1:0];
    assign w_accept = (r_state == XFER) && i_src_req[w_sel] && !i_tx_fifo_full;

    // Search starts one past the last winner and wraps, so the previous owner is checked last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_cand   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = SEL_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_found && i_src_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = 3'(w_cand);
            end
        end
    end

    always_comb begin
        o_src_ack        = '0;
        o_src_ack[w_sel] = w_accept;
    end

    assign o_tx_valid    = w_accept;
    assign o_tx_data     = i_src_data[{w_sel, 3'b000} +: 8];
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;

`ifdef UART_ARB_BURST_LIMIT_EN
    logic [7:0] r_burst_cnt;

    // The accept that brings the count up to MAX_BURST also ends the grant.
    assign w_release = i_src_last[w_sel] || (r_burst_cnt == 8'(MAX_BURST - 1));
`else
    assign w_release = i_src_last[w_sel];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= 3'(NUM_SRC - 1);
`ifdef UART_ARB_BURST_LIMIT_EN
            r_burst_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state       <= XFER;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_winner;
                        r_rr_ptr      <= w_winner;
`ifdef UART_ARB_BURST_LIMIT_EN
                        r_burst_cnt   <= '0;
`endif
                    end
                end
                XFER: begin
                    if (w_accept) begin
`ifdef UART_ARB_BURST_LIMIT_EN
                        r_burst_cnt <= r_burst_cnt + 8'd1;
`endif
                        if (w_release) begin
                            r_state       <= IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: reset, contention, backpressure, stall,
// reset mid-packet and the burst limit (or uninterrupted long packet when the limit is off).
module tb_uart_tx_arbiter;
    localparam int NSRC = 4;
    localparam int MAXB = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NSRC-1:0]     src_req;
    logic [8*NSRC-1:0]   src_data;
    logic [NSRC-1:0]     src_last;
    logic [NSRC-1:0]     src_ack;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_fifo_full;
    logic                grant_valid;
    logic [2:0]          grant_id;

    typedef struct {
        int         src;
        logic [7:0] data;
        int         cyc;
    } logEnt_t;

    logic [8:0]      srcQ [NSRC][$];
    logEnt_t         txLog[$];
    logic [NSRC-1:0] en;
    logic            rstVal;
    logic            fullVal;
    int              cycNo      = 0;
    int              checkCount = 0;
    int              passCount  = 0;
    int              failCount  = 0;

    uart_tx_arbiter #(.NUM_SRC(NSRC), .MAX_BURST(MAXB)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_src_req      (src_req),
        .i_src_data     (src_data),
        .i_src_last     (src_last),
        .o_src_ack      (src_ack),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_fifo_full (tx_fifo_full),
        .o_grant_valid  (grant_valid),
        .o_grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic loadPacket(input int src, input logic [7:0] first, input int n, input int inc);
        for (int k = 0; k < n; k++)
            srcQ[src].push_back({(k == n - 1), 8'(int'(first) + k * inc)});
    endtask

    // One clock: drive sources at the falling edge, sample 1 ns later, consume acked bytes.
    task automatic applyStimulus();
        @(negedge clk);
        rst_n        = rstVal;
        tx_fifo_full = fullVal;
        for (int i = 0; i < NSRC; i++) begin
            if (en[i] && srcQ[i].size() > 0) begin
                src_req[i]        = 1'b1;
                src_data[8*i +: 8] = srcQ[i][0][7:0];
                src_last[i]       = srcQ[i][0][8];
            end else begin
                src_req[i]        = 1'b0;
                src_data[8*i +: 8] = 8'h00;
                src_last[i]       = 1'b0;
            end
        end
        #1;
        if (fullVal) checkOutput("valid_when_full", {31'd0, tx_valid}, 32'd0);
        for (int i = 0; i < NSRC; i++) begin
            if (src_ack[i]) begin
                txLog.push_back('{src: i, data: tx_data, cyc: cycNo});
                if (srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            end
        end
        cycNo++;
    endtask

    initial begin
        int base;
        int expSrc [15];
        int expCyc [15];
        logic [7:0] expData [12];
        int expBsrc [12];

        rst_n = 1'b0; tx_fifo_full = 1'b0;
        src_req = '0; src_data = '0; src_last = '0;
        rstVal = 1'b0; fullVal = 1'b0; en = '1;

        // Reset with every source requesting, then release into contention.
        loadPacket(0, 8'hA0, 3, 0);
        loadPacket(0, 8'hA0, 3, 0);
        loadPacket(1, 8'hA1, 3, 0);
        loadPacket(2, 8'hA2, 3, 0);
        loadPacket(3, 8'hA3, 3, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_src_ack", {28'd0, src_ack}, 32'd0);
        checkOutput("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        rstVal = 1'b1;
        base   = cycNo;
        applyStimulus();
        checkOutput("release_grant_valid", {31'd0, grant_valid}, 32'd0);
        applyStimulus();
        checkOutput("first_grant_valid", {31'd0, grant_valid}, 32'd1);
        checkOutput("first_grant_id", {29'd0, grant_id}, 32'd0);
        for (int c = 0; c < 20; c++) applyStimulus();
        expSrc = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
        expCyc = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15, 17, 18, 19};
        checkOutput("cont_count", txLog.size(), 32'd15);
        for (int j = 0; j < 15; j++) begin
            if (j < txLog.size()) begin
                checkOutput($sformatf("cont_src_%0d", j), txLog[j].src, expSrc[j]);
                checkOutput($sformatf("cont_data_%0d", j), {24'd0, txLog[j].data}, 32'hA0 + expSrc[j]);
                checkOutput($sformatf("cont_cyc_%0d", j), txLog[j].cyc - base, expCyc[j]);
            end
        end

        // Backpressure: FIFO full for 3 cycles out of every 6.
        txLog.delete();
        en = 4'b0001;
        loadPacket(0, 8'h00, 20, 1);
        for (int k = 0; k < 150 && srcQ[0].size() > 0; k++) begin
            fullVal = ((k / 3) % 2) == 1;
            applyStimulus();
        end
        fullVal = 1'b0;
        checkOutput("bp_drained", srcQ[0].size(), 32'd0);
        checkOutput("bp_ack_count", txLog.size(), 32'd20);
        for (int j = 0; j < 20; j++) begin
            if (j < txLog.size()) begin
                checkOutput($sformatf("bp_data_%0d", j), {24'd0, txLog[j].data}, j);
                checkOutput($sformatf("bp_src_%0d", j), txLog[j].src, 32'd0);
            end
        end

        // Stall: source 2 pauses mid-packet while source 1 waits.
        txLog.delete();
        en = 4'b0100;
        loadPacket(2, 8'hC0, 3, 1);
        applyStimulus();
        checkOutput("stall_idle_before", {31'd0, grant_valid}, 32'd0);
        applyStimulus();
        checkOutput("stall_grant_id", {29'd0, grant_id}, 32'd2);
        applyStimulus();
        en = 4'b0010;
        loadPacket(1, 8'hB0, 2, 1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput($sformatf("stall_hold_id_%0d", c), {29'd0, grant_id}, 32'd2);
            checkOutput($sformatf("stall_hold_gv_%0d", c), {31'd0, grant_valid}, 32'd1);
            checkOutput($sformatf("stall_no_ack_%0d", c), {28'd0, src_ack}, 32'd0);
        end
        en = 4'b0110;
        applyStimulus();
        checkOutput("stall_resume_ack", {28'd0, src_ack}, 32'h4);
        applyStimulus();
        checkOutput("stall_dead_cycle", {31'd0, grant_valid}, 32'd0);
        applyStimulus();
        checkOutput("stall_next_id", {29'd0, grant_id}, 32'd1);
        checkOutput("stall_next_ack", {28'd0, src_ack}, 32'h2);
        applyStimulus();
        checkOutput("stall_count", txLog.size(), 32'd5);
        if (txLog.size() == 5) begin
            checkOutput("stall_seq_2", {24'd0, txLog[2].data}, 32'hC2);
            checkOutput("stall_seq_3", {24'd0, txLog[3].data}, 32'hB0);
            checkOutput("stall_seq_4", {24'd0, txLog[4].data}, 32'hB1);
        end

        // Reset after the first byte of a 4-byte packet from source 3.
        txLog.delete();
        en = 4'b1000;
        loadPacket(3, 8'hD0, 4, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("mid_first_ack", {28'd0, src_ack}, 32'h8);
        en     = 4'b1001;
        rstVal = 1'b0;
        loadPacket(0, 8'hE0, 1, 0);
        applyStimulus();
        checkOutput("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("mid_rst_ack", {28'd0, src_ack}, 32'd0);
        checkOutput("mid_rst_gv", {31'd0, grant_valid}, 32'd0);
        checkOutput("mid_rst_id", {29'd0, grant_id}, 32'd0);
        srcQ[3].delete();
        loadPacket(3, 8'hD0, 4, 1);
        rstVal = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("mid_restart_id", {29'd0, grant_id}, 32'd0);
        checkOutput("mid_restart_data", {24'd0, tx_data}, 32'hE0);
        applyStimulus();
        checkOutput("one_byte_released", {31'd0, grant_valid}, 32'd0);
        applyStimulus();
        checkOutput("mid_src3_id", {29'd0, grant_id}, 32'd3);
        checkOutput("mid_src3_data", {24'd0, tx_data}, 32'hD0);
        for (int c = 0; c < 5; c++) applyStimulus();
        checkOutput("mid_src3_drained", srcQ[3].size(), 32'd0);

        // Long packet from source 0 with source 1 waiting.
        txLog.delete();
        en = 4'b0011;
        loadPacket(0, 8'h50, 10, 1);
        loadPacket(1, 8'h60, 2, 1);
`ifdef UART_ARB_BURST_LIMIT_EN
        expData = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61,
                    8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
        expBsrc = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
`else
        expData = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
                    8'h56, 8'h57, 8'h58, 8'h59, 8'h60, 8'h61};
        expBsrc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`endif
        for (int k = 0; k < 80 && (srcQ[0].size() > 0 || srcQ[1].size() > 0); k++)
            applyStimulus();
        checkOutput("burst_count", txLog.size(), 32'd12);
        for (int j = 0; j < 12; j++) begin
            if (j < txLog.size()) begin
                checkOutput($sformatf("burst_data_%0d", j), {24'd0, txLog[j].data}, {24'd0, expData[j]});
                checkOutput($sformatf("burst_src_%0d", j), txLog[j].src, expBsrc[j]);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
